// File: rtl/rgb_pwm_gen.sv
// Three-channel 8-bit PWM generator with double-buffered duty registers and period strobe.
// Optional build macro RGB_PWM_PHASE_EN staggers the channel compare phases by 0/85/170 steps.
module rgb_pwm_gen #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic       clk_div,
    input  logic       rst,
    input  logic       en,
    input  logic       duty_load,
    input  logic [7:0] r_duty,
    input  logic [7:0] g_duty,
    input  logic [7:0] b_duty,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b,
    output logic       period_start,
    output logic       update_pending
);

    localparam logic [15:0] PCNT_MAX = 16'(PRESCALE - 1);

    logic [15:0] pcnt;
    logic [7:0]  cnt;
    logic        tick;
    logic        boundary;

    logic [7:0]  duty_in [3];
    logic [7:0]  pend    [3];
    logic [7:0]  act     [3];
    logic [2:0]  pwm_next;
    logic [2:0]  pwm_q;

    function automatic logic [7:0] phase_off(input int unsigned ch);
`ifdef RGB_PWM_PHASE_EN
        case (ch)
            1:       phase_off = 8'd85;
            2:       phase_off = 8'd170;
            default: phase_off = 8'd0;
        endcase
`else
        phase_off = 8'd0;
`endif
    endfunction

    assign duty_in[0] = r_duty;
    assign duty_in[1] = g_duty;
    assign duty_in[2] = b_duty;

    assign tick     = en && (pcnt == PCNT_MAX);
    assign boundary = tick && (cnt == 8'hFF);

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            cnt  <= '0;
        end else if (!en) begin
            pcnt <= '0;
            cnt  <= '0;
        end else if (tick) begin
            pcnt <= '0;
            cnt  <= cnt + 8'd1;
        end else begin
            pcnt <= pcnt + 16'd1;
        end
    end

    // While idle, a load bypasses pending so active tracks the new duty on the next cycle.
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            for (int unsigned ch = 0; ch < 3; ch++) begin
                pend[ch] <= '0;
                act[ch]  <= '0;
            end
            update_pending <= 1'b0;
        end else begin
            for (int unsigned ch = 0; ch < 3; ch++) begin
                if (!en)
                    act[ch] <= duty_load ? duty_in[ch] : pend[ch];
                else if (boundary)
                    act[ch] <= pend[ch];
                if (duty_load)
                    pend[ch] <= duty_in[ch];
            end
            if (!en)
                update_pending <= 1'b0;
            else if (duty_load)
                update_pending <= 1'b1;
            else if (boundary)
                update_pending <= 1'b0;
        end
    end

    always_comb begin
        pwm_next = '0;
        for (int unsigned ch = 0; ch < 3; ch++) begin
            pwm_next[ch] = en && ((cnt - phase_off(ch)) < act[ch]);
        end
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            pwm_q        <= '0;
            period_start <= 1'b0;
        end else begin
            pwm_q        <= pwm_next;
            period_start <= boundary;
        end
    end

    assign pwm_r = pwm_q[0];
    assign pwm_g = pwm_q[1];
    assign pwm_b = pwm_q[2];

endmodule
